// File: rtl/matriz_determ_seq.sv
// matriz_determ_seq: sequential 2x2/3x3 signed determinant with one shared multiplier and start/done handshake.
module matriz_determ_seq #(
  parameter int W = 8,
  parameter int DIM = 5,
  parameter int SAT = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   size,
  input  logic [DIM*DIM*W-1:0]   matriz_A,
  output logic                   busy,
  output logic                   done,
  output logic [W-1:0]           det,
  output logic [3*W+1:0]         det_full,
  output logic                   overflow
);
  typedef enum logic [2:0] {IDLE, MIN_A, MIN_B, MAC, FIN} state_t;
  state_t state, state_nx;
  logic signed [W-1:0] a [3][3];
  logic sz;
  logic [1:0] k, c0, c1;
  logic signed [2*W:0] minor, mb;
  logic signed [3*W+1:0] acc, res;
  logic signed [W-1:0] x, y, u, v, ma, vsel;
  logic signed [3*W:0] max, mbx, prod;
  logic ovf;
  logic [W-1:0] narrow;
  logic unused;
  assign unused = ^matriz_A;
  // For 3x3, the minor of column k uses the two other columns of rows 1 and 2.
  always_comb begin
    c0 = (k == 2'd0) ? 2'd1 : 2'd0;
    c1 = (k == 2'd2) ? 2'd1 : 2'd2;
    x = sz ? a[1][c0] : a[0][0];
    y = sz ? a[2][c1] : a[1][1];
    u = sz ? a[1][c1] : a[0][1];
    v = sz ? a[2][c0] : a[1][0];
    ma = (state == MAC) ? a[0][k] : (state == MIN_B) ? u : x;
    vsel = (state == MIN_B) ? v : y;
    mb = (state == MAC) ? minor : {{(W+1){vsel[W-1]}}, vsel};
    max = {{(2*W+1){ma[W-1]}}, ma};
    mbx = {{W{mb[2*W]}}, mb};
    prod = max * mbx;
    res = sz ? acc : {{(W+1){minor[2*W]}}, minor};
    ovf = !(&res[3*W+1:W-1] || ~|res[3*W+1:W-1]);
    narrow = (SAT != 0 && ovf) ? (res[3*W+1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                               : res[W-1:0];
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = start ? MIN_A : IDLE;
      MIN_A: state_nx = MIN_B;
      MIN_B: state_nx = sz ? MAC : FIN;
      MAC:   state_nx = (k == 2'd2) ? FIN : MIN_A;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      k <= '0;
      sz <= 1'b0;
      minor <= '0;
      acc <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      det <= '0;
      det_full <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          a[i][j] <= '0;
    end else begin
      state <= state_nx;
      done <= (state == FIN);
      case (state)
        IDLE: if (start) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              a[i][j] <= matriz_A[(i*DIM+j)*W +: W];
          sz <= size;
          k <= '0;
          acc <= '0;
          busy <= 1'b1;
        end
        MIN_A: minor <= prod[2*W:0];
        MIN_B: minor <= minor - prod[2*W:0];
        MAC: begin
          acc <= k[0] ? acc - {prod[3*W], prod} : acc + {prod[3*W], prod};
          k <= (k == 2'd2) ? 2'd0 : k + 2'd1;
        end
        FIN: begin
          acc <= res;
          det_full <= res;
          det <= narrow;
          overflow <= ovf;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_matriz_determ_seq.sv
// tb_matriz_determ_seq: directed and back-to-back random checks of the determinant unit, wrap and saturate builds.
module tb_matriz_determ_seq;
  localparam int W = 8;
  localparam int DIM = 5;
  logic clk = 0, rst_n = 0, start = 0, size = 0;
  logic [DIM*DIM*W-1:0] matriz_A = '0;
  logic busy0, done0, ovf0, busy1, done1, ovf1;
  logic [W-1:0] det0, det1;
  logic [3*W+1:0] full0, full1;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  matriz_determ_seq #(.W(W), .DIM(DIM), .SAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .size(size), .matriz_A(matriz_A),
    .busy(busy0), .done(done0), .det(det0), .det_full(full0), .overflow(ovf0));
  matriz_determ_seq #(.W(W), .DIM(DIM), .SAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .size(size), .matriz_A(matriz_A),
    .busy(busy1), .done(done1), .det(det1), .det_full(full1), .overflow(ovf1));

  // Fills the whole operand with noise, then places m (3x3 row-major) in the leading corner.
  task automatic load(input int m[9]);
    for (int e = 0; e < DIM*DIM; e++) matriz_A[e*W +: W] = W'($urandom);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        matriz_A[(i*DIM+j)*W +: W] = W'(m[i*3+j]);
  endtask

  function automatic longint ref_det(input int m[9], input bit sz);
    longint r;
    if (!sz) r = longint'(m[0])*m[4] - longint'(m[1])*m[3];
    else r = longint'(m[0])*(m[4]*m[8]-m[5]*m[7]) - longint'(m[1])*(m[3]*m[8]-m[5]*m[6])
           + longint'(m[2])*(m[3]*m[7]-m[4]*m[6]);
    return r;
  endfunction

  task automatic run(input bit sz, output int lat);
    @(negedge clk);
    size = sz;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    lat = 0;
    while (!done0 && lat < 30) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    total++;
    if ({busy0, done0, full0, det0, ovf0, busy1, done1, full1, det1, ovf1} !== '0) begin
      bad++;
      $display("FAIL reset: busy=%b done=%b full=%h det=%h ovf=%b, required all zero", busy0, done0, full0, det0, ovf0);
    end
    rst_n = 1;
  endtask

  task automatic test_2x2;
    int v[9];
    int lat;
    v = '{3, 4, 0, 2, 5, 0, 0, 0, 0};
    load(v);
    run(0, lat);
    total++;
    if (lat !== 3) begin bad++; $display("FAIL 2x2 latency: got %0d, required 3", lat); end
    total++;
    if (full0 !== 26'd7 || det0 !== 8'd7 || ovf0 !== 1'b0 || det1 !== 8'd7) begin
      bad++;
      $display("FAIL 2x2 value: full=%0d det=%0d ovf=%b sat_det=%0d, required 7 7 0 7", full0, det0, ovf0, det1);
    end
    total++;
    if (busy0 !== 1'b0) begin bad++; $display("FAIL 2x2 busy at done: got %b, required 0", busy0); end
    @(posedge clk);
    #1 total++;
    if (done0 !== 1'b0 || det0 !== 8'd7) begin
      bad++;
      $display("FAIL 2x2 done pulse/hold: done=%b det=%0d, required 0 7", done0, det0);
    end
  endtask

  task automatic test_overflow_2x2;
    int v[9];
    int lat;
    v = '{100, -100, 0, 100, 100, 0, 0, 0, 0};
    load(v);
    run(0, lat);
    total++;
    if (full0 !== 26'd20000 || ovf0 !== 1'b1 || ovf1 !== 1'b1) begin
      bad++;
      $display("FAIL ovf2x2 full: full=%0d ovf=%b/%b, required 20000 1/1", full0, ovf0, ovf1);
    end
    total++;
    if (det0 !== 8'h20 || det1 !== 8'h7f) begin
      bad++;
      $display("FAIL ovf2x2 narrow: wrap=%h sat=%h, required 20 7f", det0, det1);
    end
  endtask

  task automatic test_3x3_midrun;
    int v[9], w[9];
    int lat, seen;
    v = '{2, -3, 1, 2, 0, -1, 1, 4, 5};
    w = '{9, 9, 9, 1, 2, 3, -7, 5, 6};
    load(v);
    @(negedge clk);
    size = 1;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    lat = 0;
    while (!done0 && lat < 30) begin
      @(posedge clk);
      #1 lat++;
      if (lat == 4) begin load(w); size = 0; start = 1; end
      if (lat == 5) start = 0;
    end
    total++;
    if (lat !== 10) begin bad++; $display("FAIL 3x3 latency: got %0d, required 10", lat); end
    total++;
    if (full0 !== 26'd49 || det0 !== 8'd49 || ovf0 !== 1'b0 || det1 !== 8'd49) begin
      bad++;
      $display("FAIL 3x3 value: full=%0d det=%0d ovf=%b sat=%0d, required 49 49 0 49", full0, det0, ovf0, det1);
    end
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (busy0 || done0) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL 3x3 start ignored: busy/done seen %0d cycles, required 0", seen); end
  endtask

  task automatic test_sat_3x3;
    int v[9];
    int lat;
    v = '{-128, -128, 0, 127, -128, 0, 0, 0, 1};
    load(v);
    run(1, lat);
    total++;
    if (full0 !== 26'd32640 || ovf0 !== 1'b1 || det0 !== 8'h80 || det1 !== 8'h7f) begin
      bad++;
      $display("FAIL sat3x3 pos: full=%0d ovf=%b wrap=%h sat=%h, required 32640 1 80 7f", full0, ovf0, det0, det1);
    end
    v = '{-128, -128, 0, -128, 127, 0, 0, 0, 1};
    load(v);
    run(1, lat);
    total++;
    if (full0 !== 26'(-32640) || ovf1 !== 1'b1 || det0 !== 8'h80 || det1 !== 8'h80) begin
      bad++;
      $display("FAIL sat3x3 neg: full=%h ovf=%b wrap=%h sat=%h, required %h 1 80 80", full0, ovf1, det0, det1, 26'(-32640));
    end
  endtask

  task automatic test_reset_midrun;
    int v[9];
    int lat, seen;
    v = '{2, -3, 1, 2, 0, -1, 1, 4, 5};
    load(v);
    @(negedge clk);
    size = 1;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (5) @(posedge clk);
    #2 rst_n = 0;
    #1 total++;
    if ({busy0, done0, full0, det0, ovf0} !== '0) begin
      bad++;
      $display("FAIL midreset outputs: busy=%b done=%b full=%h det=%h ovf=%b, required zero", busy0, done0, full0, det0, ovf0);
    end
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      rst_n = 1;
      if (done0 || busy0) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL midreset no done: busy/done seen %0d cycles, required 0", seen); end
    v = '{3, 4, 0, 2, 5, 0, 0, 0, 0};
    load(v);
    run(0, lat);
    total++;
    if (lat !== 3 || full0 !== 26'd7 || det0 !== 8'd7) begin
      bad++;
      $display("FAIL midreset rerun: lat=%0d full=%0d det=%0d, required 3 7 7", lat, full0, det0);
    end
  endtask

  task automatic test_back_to_back(input bit sz, input int n);
    int cur[9], nxt[9];
    int p;
    longint e;
    logic [W-1:0] e0, e1;
    logic eo;
    p = sz ? 11 : 4;
    for (int j = 0; j < 9; j++) cur[j] = int'($urandom_range(0, 255)) - 128;
    load(cur);
    @(negedge clk);
    size = sz;
    start = 1;
    for (int i = 0; i < n; i++) begin
      e = ref_det(cur, sz);
      eo = (e > 127 || e < -128);
      e0 = W'(e);
      e1 = eo ? (e < 0 ? 8'h80 : 8'h7f) : e0;
      @(posedge clk);
      #1 for (int j = 0; j < 9; j++) nxt[j] = int'($urandom_range(0, 255)) - 128;
      load(nxt);
      repeat (p - 2) @(posedge clk);
      #1 total++;
      if (done0 !== 1'b0) begin bad++; $display("FAIL b2b%0d early done at item %0d: got %b, required 0", sz ? 3 : 2, i, done0); end
      @(posedge clk);
      #1 total++;
      if ({done0, full0, det0, det1, ovf0, ovf1} !== {1'b1, 26'(e), e0, e1, eo, eo}) begin
        bad++;
        $display("FAIL b2b%0d item %0d: done=%b full=%h det=%h sat=%h ovf=%b, required 1 %h %h %h %b",
                 sz ? 3 : 2, i, done0, full0, det0, det1, ovf0, 26'(e), e0, e1, eo);
      end
      cur = nxt;
    end
    start = 0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    test_reset;
    test_2x2;
    test_overflow_2x2;
    test_3x3_midrun;
    test_sat_3x3;
    test_reset_midrun;
    test_back_to_back(0, 1000);
    test_back_to_back(1, 1000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/matriz_determ_seq.md
# matriz_determ_seq

Sequential, parametrised determinant unit for the coprocessor ULA. It computes the signed determinant of the 2x2 or 3x3 leading sub-matrix of a packed 5x5 operand, using one shared signed multiplier and a start/done handshake. The result is available at full precision, and also narrowed to the element width with an overflow flag and optional saturation. It replaces purely combinational 2x2-only determinant logic in the ULA datapath.

## Interface
- W, default 8: element and narrowed-result width; elements are two's-complement signed.
- DIM, default 5: side length of the packed operand matrix.
- SAT, default 0: narrowing mode. 0 wraps to the low W bits; 1 saturates to the signed W-bit range.
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled only in IDLE.
- size  input  1  0 selects 2x2, 1 selects 3x3. Sampled with start.
- matriz_A  input  DIM*DIM*W  row-major matrix; element (i,j) is at bits [(i*DIM+j)*W +: W].
- busy  output  1  high from the accepting edge until the edge that raises done.
- done  output  1  one-cycle pulse when det, det_full and overflow are valid.
- det  output  W  narrowed determinant, held until the next done.
- det_full  output  3W+2  exact signed determinant, held until the next done.
- overflow  output  1  det_full is outside [-2^(W-1), 2^(W-1)-1]; held with det.

## Operation
- A start seen in IDLE latches matriz_A (rows/cols 0..2 only) and size into an internal operand register. Later input changes have no effect on the operation in progress.
- start while busy is ignored. It is not queued.
- States: IDLE, MIN_A, MIN_B, MAC, FIN. The column index k is 0..2.
- MIN_A: minor <= x*y.
- MIN_B: minor <= minor - u*v. The minor register is 2W+1 signed bits.
  - For 2x2: x=a00, y=a11, u=a01, v=a10.
  - For 3x3, column k with remaining columns c0<c1: x=a1c0, y=a2c1, u=a1c1, v=a2c0.
- 2x2 path: MIN_A -> MIN_B -> FIN. FIN loads acc <= minor.
- 3x3 path: acc cleared on accept. For each k: MIN_A -> MIN_B -> MAC, where MAC does acc <= acc + (-1)^k * a0k * minor.
  - After MAC with k<2, go to MIN_A with k+1.
  - After MAC with k=2, go to FIN.
- acc is 3W+2 bits signed. No intermediate overflow is possible.
- One multiplication per cycle at most. All products are signed x signed, sign-extended before add/sub.
- FIN: register det_full <= acc and overflow <= range check.
  - det <= acc[W-1:0] when SAT=0 or in range.
  - Otherwise det <= 2^(W-1)-1 if positive, -2^(W-1) if negative.
  - Pulse done, drop busy, return to IDLE.
- rst_n low at any time, including mid-operation, forces IDLE immediately. The operation is abandoned with no done.

## Timing
- Reset values: busy=0, done=0, det=0, det_full=0, overflow=0, state IDLE, k=0.
- start accepted at edge T gives busy=1 after T.
- 2x2: done=1 and outputs valid after edge T+3.
- 3x3: done=1 and outputs valid after edge T+10.
- busy falls on the same edge that raises done.
- done is high exactly one cycle.
- A new start is accepted on the edge where done is high at the earliest, i.e. the first edge with the state in IDLE. Back-to-back throughput is 4 cycles for 2x2 and 11 cycles for 3x3.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- Reset, then 2x2 [[3,4],[2,5]], size=0 -> done at T+3, det=7, det_full=7, overflow=0.
- 2x2 [[100,-100],[100,100]], W=8 -> det_full=20000, overflow=1. SAT=0 gives det=0x20; SAT=1 gives det=0x7F.
- 3x3 [[2,-3,1],[2,0,-1],[1,4,5]], size=1 -> done at T+10, det=49, overflow=0. Change matriz_A and pulse start mid-run -> result still 49, second start ignored.
- 3x3 [[-128,-128,0],[127,-128,0],[0,0,1]] -> det_full=32640, overflow=1. SAT=1 gives det=0x7F; an all-negative variant gives 0x80.
- Assert rst_n low at T+5 of a 3x3 run -> busy=0, done never pulses, outputs 0. A subsequent 2x2 run is correct.
- Back-to-back: start held high continuously -> done every 4 cycles (2x2) and every 11 cycles (3x3), each result matching a software reference over 1000 random matrices.
